mem_model_param: RTL

- Parametrised single-port synchronous memory. It is the next generation of the team's fixed-size memory model.
- Generalised in data width, depth and read latency.
- Adds a valid/ready request handshake, byte-enable writes and a pipelined response channel.
- Adds an error flag for out-of-range addresses and an optional hardware clear sweep after reset.
- Sits behind the bus interface as the DUT driven by the team's driver/monitor/scoreboard testbench.

---
 rtl/mem_model_param_if.sv | 29 ++
 rtl/mem_model_param.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_model_param_if.sv
// Request/response bus for mem_model_param: valid/ready request channel,
// unthrottled pipelined response channel and the init-sweep busy flag.
interface mem_model_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/mem_model_param.sv
// Parametrised single-port synchronous memory with byte-enable writes, an
// out-of-range error flag, optional zeroing sweep after reset and a fixed-latency response pipe.
module mem_model_param #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEPTH      = 20,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_model_param_if.slave bus
);

  localparam int unsigned      BE_W     = DATA_W / 8;
  localparam int unsigned      CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              in_range;
  logic              clr_we;
  logic              wr_we;
  logic [CNT_W-1:0]  word_idx;
  logic [DATA_W-1:0] rd_word;

  logic [RD_LAT-1:0] pipe_vld_q;
  logic [RD_LAT-1:0] pipe_err_q;
  logic [DATA_W-1:0] pipe_data_q [RD_LAT];

  // Gating with rst keeps the block closed for the whole time reset is held.
  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign bus.busy      = (state_q == StInit);

  assign accept   = bus.req_valid && bus.req_ready;
  assign in_range = {1'b0, bus.req_addr} < DEPTH_A;
  assign word_idx = bus.req_addr[CNT_W-1:0];
  assign clr_we   = (state_q == StInit) && !rst;
  assign wr_we    = accept && bus.req_wr && in_range;
  assign rd_word  = in_range ? mem_q[word_idx] : '0;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StInit: begin
        clr_cnt_d = clr_cnt_q + CNT_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end
      end
      StIdle:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLR_ON_RST != 0) ? StInit : StIdle;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage has no reset: contents survive reset unless the sweep clears them.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) begin
          mem_q[word_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= accept;
      pipe_err_q[0]  <= accept && !in_range;
      pipe_data_q[0] <= (accept && !bus.req_wr) ? rd_word : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_err_q[i]  <= pipe_err_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign bus.rsp_valid = pipe_vld_q[RD_LAT-1];
  assign bus.rsp_err   = pipe_err_q[RD_LAT-1];
  assign bus.rsp_rdata = pipe_data_q[RD_LAT-1];

endmodule
